// File: rtl/uart_frame_parser_if.sv
// Byte-stream, host-handshake and payload-read signals shared between the
// UART frame parser and the logic that feeds and drains it.
interface uart_frame_parser_if #(
    parameter int ADDR_W = 4
) ();
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              frame_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              frame_ready;
    logic [7:0]        frame_cmd;
    logic [7:0]        frame_len;
    logic              busy;
    logic              err_chk;
    logic              err_len;
    logic              err_timeout;
    logic              err_ovr;

    modport master (
        output byte_in, byte_valid, frame_ack, rd_addr,
        input  rd_data, frame_ready, frame_cmd, frame_len, busy,
               err_chk, err_len, err_timeout, err_ovr
    );

    modport slave (
        input  byte_in, byte_valid, frame_ack, rd_addr,
        output rd_data, frame_ready, frame_cmd, frame_len, busy,
               err_chk, err_len, err_timeout, err_ovr
    );
endinterface

// File: rtl/uart_frame_parser.sv
// Assembles SYNC/CMD/LEN/payload/CHK frames from a UART byte stream, holds
// good frames for the host until acknowledged and pulses an error on bad ones.
module uart_frame_parser #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          MAX_LEN        = 16,
    parameter int          ADDR_W         = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500000
) (
    input  logic            clk,
    input  logic            rst,
    uart_frame_parser_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CHK, S_HOLD
    } state_t;

    localparam logic [8:0]      MAX_LEN_W = 9'(MAX_LEN);
    localparam logic [ADDR_W:0] IDX_ONE   = (ADDR_W+1)'(1);

    state_t          state_reg, state_next;
    logic [31:0]     cnt_reg, cnt_next;
    logic [7:0]      chk_reg, chk_next;
    logic [ADDR_W:0] idx_reg, idx_next;
    logic [7:0]      cmd_reg, cmd_next;
    logic [7:0]      len_reg, len_next;
    logic            frame_ready_reg, frame_ready_next;
    logic [7:0]      frame_cmd_reg, frame_cmd_next;
    logic [7:0]      frame_len_reg, frame_len_next;
    logic            busy_reg, busy_next;
    logic            err_chk_reg, err_chk_next;
    logic            err_len_reg, err_len_next;
    logic            err_timeout_reg, err_timeout_next;
    logic            err_ovr_reg, err_ovr_next;
    logic [7:0]      rd_data_reg;
    logic            wr_en;
    logic            timeout_hit;
    logic [ADDR_W:0] idx_inc;

    logic [7:0] mem [0:(2**ADDR_W)-1];

    assign timeout_hit = !bus.byte_valid && (cnt_reg == TIMEOUT_CYCLES - 32'd1);
    assign idx_inc     = idx_reg + IDX_ONE;

    always_comb begin
        state_next       = state_reg;
        cnt_next         = 32'd0;
        chk_next         = chk_reg;
        idx_next         = idx_reg;
        cmd_next         = cmd_reg;
        len_next         = len_reg;
        frame_ready_next = frame_ready_reg;
        frame_cmd_next   = frame_cmd_reg;
        frame_len_next   = frame_len_reg;
        err_chk_next     = 1'b0;
        err_len_next     = 1'b0;
        err_timeout_next = 1'b0;
        err_ovr_next     = 1'b0;
        wr_en            = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (bus.byte_valid && bus.byte_in == SYNC_BYTE)
                    state_next = S_CMD;
            end
            S_HOLD: begin
                // Bytes arriving while a frame is held are lost, even when
                // the host acknowledges in the same cycle.
                if (bus.byte_valid)
                    err_ovr_next = 1'b1;
                if (bus.frame_ack) begin
                    state_next       = S_IDLE;
                    frame_ready_next = 1'b0;
                end
            end
            S_CMD, S_LEN, S_PAYLOAD, S_CHK: begin
                cnt_next = bus.byte_valid ? 32'd0 : cnt_reg + 32'd1;
                if (timeout_hit) begin
                    err_timeout_next = 1'b1;
                    state_next       = S_IDLE;
                    cnt_next         = 32'd0;
                end else if (bus.byte_valid) begin
                    case (state_reg)
                        S_CMD: begin
                            cmd_next   = bus.byte_in;
                            chk_next   = bus.byte_in;
                            state_next = S_LEN;
                        end
                        S_LEN: begin
                            chk_next = chk_reg ^ bus.byte_in;
                            len_next = bus.byte_in;
                            idx_next = '0;
                            if (bus.byte_in == 8'h00) begin
                                state_next = S_CHK;
                            end else if ({1'b0, bus.byte_in} > MAX_LEN_W) begin
                                err_len_next = 1'b1;
                                state_next   = S_IDLE;
                            end else begin
                                state_next = S_PAYLOAD;
                            end
                        end
                        S_PAYLOAD: begin
                            wr_en    = 1'b1;
                            chk_next = chk_reg ^ bus.byte_in;
                            idx_next = idx_inc;
                            if (8'(idx_inc) == len_reg)
                                state_next = S_CHK;
                        end
                        default: begin
                            if (bus.byte_in == chk_reg) begin
                                state_next       = S_HOLD;
                                frame_ready_next = 1'b1;
                                frame_cmd_next   = cmd_reg;
                                frame_len_next   = len_reg;
                            end else begin
                                err_chk_next = 1'b1;
                                state_next   = S_IDLE;
                            end
                        end
                    endcase
                end
            end
            default: state_next = S_IDLE;
        endcase

        busy_next = (state_next == S_CMD) || (state_next == S_LEN) ||
                    (state_next == S_PAYLOAD) || (state_next == S_CHK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            cnt_reg         <= 32'd0;
            chk_reg         <= 8'h00;
            idx_reg         <= '0;
            cmd_reg         <= 8'h00;
            len_reg         <= 8'h00;
            frame_ready_reg <= 1'b0;
            frame_cmd_reg   <= 8'h00;
            frame_len_reg   <= 8'h00;
            busy_reg        <= 1'b0;
            err_chk_reg     <= 1'b0;
            err_len_reg     <= 1'b0;
            err_timeout_reg <= 1'b0;
            err_ovr_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            chk_reg         <= chk_next;
            idx_reg         <= idx_next;
            cmd_reg         <= cmd_next;
            len_reg         <= len_next;
            frame_ready_reg <= frame_ready_next;
            frame_cmd_reg   <= frame_cmd_next;
            frame_len_reg   <= frame_len_next;
            busy_reg        <= busy_next;
            err_chk_reg     <= err_chk_next;
            err_len_reg     <= err_len_next;
            err_timeout_reg <= err_timeout_next;
            err_ovr_reg     <= err_ovr_next;
        end
    end

    // Payload buffer survives reset; only the frame bookkeeping is cleared.
    always_ff @(posedge clk) begin
        if (wr_en && !rst)
            mem[idx_reg[ADDR_W-1:0]] <= bus.byte_in;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_data_reg <= 8'h00;
        else if (32'(bus.rd_addr) >= 32'(frame_len_reg))
            rd_data_reg <= 8'h00;
        else
            rd_data_reg <= mem[bus.rd_addr];
    end

    assign bus.rd_data     = rd_data_reg;
    assign bus.frame_ready = frame_ready_reg;
    assign bus.frame_cmd   = frame_cmd_reg;
    assign bus.frame_len   = frame_len_reg;
    assign bus.busy        = busy_reg;
    assign bus.err_chk     = err_chk_reg;
    assign bus.err_len     = err_len_reg;
    assign bus.err_timeout = err_timeout_reg;
    assign bus.err_ovr     = err_ovr_reg;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: good/bad frames, length limits,
// inter-byte timeout, overrun while holding, and reset mid-frame.
module tb_uart_frame_parser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   n_chk = 0, n_len = 0, n_tmo = 0, n_ovr = 0;
    logic [7:0] seq [$];

    uart_frame_parser_if #(.ADDR_W(4)) bus ();

    uart_frame_parser #(
        .SYNC_BYTE(8'hA5),
        .MAX_LEN(16),
        .ADDR_W(4),
        .TIMEOUT_CYCLES(32'd100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.err_chk)     n_chk++;
        if (bus.err_len)     n_len++;
        if (bus.err_timeout) n_tmo++;
        if (bus.err_ovr)     n_ovr++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was sampled.
    task automatic send_byte(input logic [7:0] b);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        $display("tx byte=%02h ready=%0b busy=%0b", b, bus.frame_ready, bus.busy);
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_check(input logic [3:0] addr, input logic [7:0] exp, input string tag);
        bus.rd_addr = addr;
        @(negedge clk);
        $display("rd addr=%0d data=%02h", addr, bus.rd_data);
        check(tag, bus.rd_data, exp);
    endtask

    task automatic ack();
        bus.frame_ack = 1'b1;
        @(negedge clk);
        bus.frame_ack = 1'b0;
        $display("ack ready=%0b", bus.frame_ready);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, bus.frame_ready, 0);
        check({tag, "_cmd"},   bus.frame_cmd,   0);
        check({tag, "_len"},   bus.frame_len,   0);
        check({tag, "_busy"},  bus.busy,        0);
        check({tag, "_rd"},    bus.rd_data,     0);
        check({tag, "_errs"},  {bus.err_chk, bus.err_len, bus.err_timeout, bus.err_ovr}, 0);
    endtask

    initial begin
        bus.byte_in = 8'h00; bus.byte_valid = 1'b0;
        bus.frame_ack = 1'b0; bus.rd_addr = 4'd0;
        idle(3);
        check_all_zero("reset");
        rst = 1'b0;
        idle(1);

        // Test 1: good frame, then hold it for test 5
        seq = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33};
        send_seq();
        check("t1_busy_mid", bus.busy, 1);
        check("t1_ready_pre", bus.frame_ready, 0);
        send_byte(8'h13);
        check("t1_ready", bus.frame_ready, 1);
        check("t1_cmd", bus.frame_cmd, 8'h10);
        check("t1_len", bus.frame_len, 8'h03);
        check("t1_busy", bus.busy, 0);
        read_check(4'd0, 8'h11, "t1_rd0");
        read_check(4'd3, 8'h00, "t1_rd3_beyond_len");
        read_check(4'd1, 8'h22, "t1_rd1");
        read_check(4'd2, 8'h33, "t1_rd2");
        check("t1_no_errs", n_chk + n_len + n_tmo + n_ovr, 0);

        // Test 5: overrun while holding
        send_byte(8'h55);
        check("t5_ovr_pulse", bus.err_ovr, 1);
        check("t5_ready_kept", bus.frame_ready, 1);
        check("t5_rd_unchanged", bus.rd_data, 8'h33);
        idle(1);
        check("t5_ovr_single", bus.err_ovr, 0);
        read_check(4'd0, 8'h11, "t5_buf_untouched");
        ack();
        check("t5_ready_drop", bus.frame_ready, 0);

        // Test 2: bad checksum, then the good frame
        seq = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h14};
        send_seq();
        check("t2_chk_pulse", bus.err_chk, 1);
        check("t2_ready", bus.frame_ready, 0);
        idle(1);
        check("t2_chk_single", bus.err_chk, 0);
        seq = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13};
        send_seq();
        check("t2_good_after", bus.frame_ready, 1);

        // Byte and ack together in HOLD: byte dropped, frame released
        bus.frame_ack = 1'b1;
        send_byte(8'h77);
        bus.frame_ack = 1'b0;
        check("hold_ack_ovr", bus.err_ovr, 1);
        check("hold_ack_ready", bus.frame_ready, 0);
        check("hold_ack_busy", bus.busy, 0);

        // Test 3: zero-length frame, then oversize LEN
        seq = '{8'hA5, 8'h20, 8'h00, 8'h20};
        send_seq();
        check("t3_ready", bus.frame_ready, 1);
        check("t3_cmd", bus.frame_cmd, 8'h20);
        check("t3_len0", bus.frame_len, 8'h00);
        read_check(4'd0, 8'h00, "t3_rd_len0");
        ack();
        seq = '{8'hA5, 8'h20, 8'h11};
        send_seq();
        check("t3_len_pulse", bus.err_len, 1);
        check("t3_idle", bus.busy, 0);

        // Maximum length frame: 16 bytes 01..10, checksum equals CMD
        seq = '{8'hA5, 8'h30, 8'h10};
        for (int i = 1; i <= 16; i++) seq.push_back(8'(i));
        seq.push_back(8'h30);
        send_seq();
        check("max_ready", bus.frame_ready, 1);
        check("max_len", bus.frame_len, 8'h10);
        read_check(4'd0, 8'h01, "max_rd0");
        read_check(4'd15, 8'h10, "max_rd15");
        ack();

        // Errored SYNC-valued byte must not start a new frame
        seq = '{8'hA5, 8'h10, 8'h01, 8'h22, 8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13};
        send_seq();
        check("nosync_ready", bus.frame_ready, 0);
        check("nosync_busy", bus.busy, 0);

        // Test 4: inter-byte timeout
        seq = '{8'hA5, 8'h10};
        send_seq();
        idle(99);
        check("t4_no_tmo_99", bus.err_timeout, 0);
        check("t4_busy_99", bus.busy, 1);
        idle(1);
        check("t4_tmo_100", bus.err_timeout, 1);
        check("t4_idle", bus.busy, 0);
        idle(1);
        check("t4_tmo_single", bus.err_timeout, 0);
        seq = '{8'hA5, 8'h10};
        send_seq();
        idle(99);
        send_byte(8'h00);
        check("t4_byte_wins", bus.err_timeout, 0);
        check("t4_busy_kept", bus.busy, 1);
        send_byte(8'h10);
        check("t4_frame_after", bus.frame_ready, 1);
        check("t4_len", bus.frame_len, 8'h00);
        ack();

        // Reset while a frame is held clears the outputs
        seq = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13};
        send_seq();
        rst = 1'b1; idle(1); rst = 1'b0;
        check_all_zero("rst_hold");

        // Test 6: garbage ignored, reset mid-payload, then a good frame
        seq = '{8'h00, 8'hFF};
        send_seq();
        check("t6_garbage_busy", bus.busy, 0);
        seq = '{8'hA5, 8'h10, 8'h03, 8'h11};
        send_seq();
        check("t6_busy_mid", bus.busy, 1);
        rst = 1'b1; idle(1); rst = 1'b0;
        check_all_zero("t6_rst");
        seq = '{8'hA5, 8'h42, 8'h02, 8'hAA, 8'h55, 8'hBF};
        send_seq();
        check("t6_ready", bus.frame_ready, 1);
        check("t6_cmd", bus.frame_cmd, 8'h42);
        check("t6_len", bus.frame_len, 8'h02);
        read_check(4'd0, 8'hAA, "t6_rd0");
        read_check(4'd1, 8'h55, "t6_rd1");
        ack();

        idle(2);
        check("tot_err_chk", n_chk, 2);
        check("tot_err_len", n_len, 1);
        check("tot_err_tmo", n_tmo, 1);
        check("tot_err_ovr", n_ovr, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
